// File: rtl/bidir_port_ctrl_pkg.sv
// Register offsets and defaults shared by the bidirectional port controller.
package bidir_port_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_DIR  = 2'd1,
    REG_STAT = 2'd2,
    REG_MASK = 2'd3
  } reg_off_e;

  localparam logic [7:0] DEF_BASE_ADDR = 8'h10;

endpackage

// File: rtl/bidir_port_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing pad levels into the clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/bidir_port_ctrl.sv
// Processor-mapped bidirectional pad port with edge-flag interrupts.
// Edge flags, mask and interrupt exist only when BIDIR_PORT_IRQ_EN is defined.
module bidir_port_ctrl
  import bidir_port_ctrl_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned WIDTH     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  output logic [7:0]       in_port,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_o,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  logic [7:0]       off;
  logic             hit;
  logic             sel_data, sel_dir;
  logic             sel_stat, sel_mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stat_v, mask_v;
  logic             unused_in;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [7:0]       in_port_q, in_port_d;

  // Subtracting the base handles unaligned bases and wraparound.
  assign off = port_id - BASE_ADDR;
  assign hit = (off[7:2] == 6'd0);

  assign sel_data = hit && (off[1:0] == REG_DATA);
  assign sel_dir  = hit && (off[1:0] == REG_DIR);
  assign sel_stat = hit && (off[1:0] == REG_STAT);
  assign sel_mask = hit && (off[1:0] == REG_MASK);

  assign wdata = out_port[WIDTH-1:0];

  sync_2ff #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pad_o),
    .q    (sync2)
  );

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    if (write_strobe && sel_data) begin
      data_d = wdata;
    end
    if (write_strobe && sel_dir) begin
      dir_d = wdata;
    end
  end

  always_comb begin
    in_port_d = 8'h00;
    unique case (1'b1)
      sel_data: in_port_d[WIDTH-1:0] = sync2;
      sel_dir:  in_port_d[WIDTH-1:0] = dir_q;
      sel_stat: in_port_d[WIDTH-1:0] = stat_v;
      sel_mask: in_port_d[WIDTH-1:0] = mask_v;
      default:  in_port_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      dir_q     <= '1;
      in_port_q <= 8'h00;
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      in_port_q <= in_port_d;
    end
  end

  assign pad_i   = data_q;
  assign pad_t   = dir_q;
  assign in_port = in_port_q;

`ifdef BIDIR_PORT_IRQ_EN
  logic [WIDTH-1:0] sync3_q, sync3_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rise;

  assign rise = sync2 & ~sync3_q;

  always_comb begin
    sync3_d = sync2;
    stat_d  = stat_q;
    mask_d  = mask_q;
    if (write_strobe && sel_stat) begin
      stat_d = stat_q & ~wdata;
    end
    // A fresh edge beats a same-cycle clear.
    stat_d = stat_d | rise;
    if (write_strobe && sel_mask) begin
      mask_d = wdata;
    end
    irq_d = interrupt_ack ? 1'b0 : |(stat_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync3_q <= '0;
      stat_q  <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync3_q <= sync3_d;
      stat_q  <= stat_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  assign stat_v    = stat_q;
  assign mask_v    = mask_q;
  assign interrupt = irq_q;
  assign unused_in = read_strobe;
`else
  assign stat_v    = '0;
  assign mask_v    = '0;
  assign interrupt = 1'b0;
  assign unused_in = read_strobe ^ interrupt_ack;
`endif

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Self-checking bench for bidir_port_ctrl (vector table plus corner sequences).
module tb_bidir_port_ctrl;

`ifdef BIDIR_PORT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic [7:0] pad_i;
  logic [7:0] pad_t;
  logic [7:0] pad_o;
  logic       interrupt;
  logic       interrupt_ack;

  always #5 clk = ~clk;

  bidir_port_ctrl #(
    .BASE_ADDR(8'h10),
    .WIDTH    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .pad_i        (pad_i),
    .pad_t        (pad_t),
    .pad_o        (pad_o),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  typedef struct {
    logic       we;
    logic [7:0] pid;
    logic [7:0] wd;
    logic [7:0] t;
    logic [7:0] i;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string name, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sbq.pop_front();
      chk(e.name, in_port, e.v);
    end
  endtask

  task automatic wr(input logic [7:0] pid, input logic [7:0] d);
    port_id      = pid;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    out_port      = 8'h00;
    pad_o         = 8'h00;
    interrupt_ack = 1'b0;

    //          we    pid    wd     pad_t  pad_i  in_port
    vecs[0]  = '{1'b1, 8'h11, 8'h0F, 8'h0F, 8'h00, 8'hFF};
    vecs[1]  = '{1'b1, 8'h10, 8'hA5, 8'h0F, 8'hA5, 8'h00};
    vecs[2]  = '{1'b0, 8'h11, 8'h00, 8'h0F, 8'hA5, 8'h0F};
    vecs[3]  = '{1'b0, 8'h10, 8'h00, 8'h0F, 8'hA5, 8'h00};
    vecs[4]  = '{1'b1, 8'h14, 8'h33, 8'h0F, 8'hA5, 8'h00};
    vecs[5]  = '{1'b1, 8'h0F, 8'h00, 8'h0F, 8'hA5, 8'h00};
    vecs[6]  = '{1'b0, 8'h12, 8'h00, 8'h0F, 8'hA5, 8'h00};
    vecs[7]  = '{1'b1, 8'h13, 8'h5A, 8'h0F, 8'hA5, 8'h00};
    vecs[8]  = '{1'b0, 8'h13, 8'h00, 8'h0F, 8'hA5,
                 IRQ ? 8'h5A : 8'h00};
    vecs[9]  = '{1'b1, 8'h13, 8'h00, 8'h0F, 8'hA5,
                 IRQ ? 8'h5A : 8'h00};
    vecs[10] = '{1'b1, 8'h11, 8'h00, 8'h00, 8'hA5, 8'h0F};
    vecs[11] = '{1'b1, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'h00};

    tick(2);
    chk("rst pad_t", pad_t, 8'hFF);
    chk("rst pad_i", pad_i, 8'h00);
    chk("rst in_port", in_port, 8'h00);
    chk("rst irq", {7'b0, interrupt}, 8'h00);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      port_id      = vecs[k].pid;
      write_strobe = vecs[k].we;
      read_strobe  = ~vecs[k].we;
      out_port     = vecs[k].wd;
      sb_push($sformatf("vec%0d in_port", k), vecs[k].rd);
      tick();
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      chk($sformatf("vec%0d pad_t", k), pad_t, vecs[k].t);
      chk($sformatf("vec%0d pad_i", k), pad_i, vecs[k].i);
      sb_check();
    end

    // Pad to DATA read latency: two sync flops plus the read register.
    port_id = 8'h10;
    pad_o   = 8'h3C;
    sb_push("sync lat c1", 8'h00);
    sb_push("sync lat c2", 8'h00);
    sb_push("sync lat c3", 8'h3C);
    for (int k = 0; k < 3; k++) begin
      tick();
      sb_check();
    end
    wr(8'h12, 8'hFF);
    chk("stat 3c", in_port, IRQ ? 8'h3C : 8'h00);
    tick();
    chk("stat clr", in_port, 8'h00);
    pad_o = 8'h00;
    tick(4);

`ifdef BIDIR_PORT_IRQ_EN
    wr(8'h13, 8'h01);
    port_id = 8'h12;
    pad_o   = 8'h01;
    tick(3);
    chk("irq early", {7'b0, interrupt}, 8'h00);
    tick();
    chk("irq set", {7'b0, interrupt}, 8'h01);
    chk("stat 01", in_port, 8'h01);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("irq ack", {7'b0, interrupt}, 8'h00);
    tick();
    chk("irq reassert", {7'b0, interrupt}, 8'h01);
    chk("stat kept", in_port, 8'h01);
    pad_o = 8'h00;
    tick(3);
    chk("irq held", {7'b0, interrupt}, 8'h01);
    wr(8'h12, 8'h01);
    chk("irq pre clr", {7'b0, interrupt}, 8'h01);
    tick();
    chk("irq drop", {7'b0, interrupt}, 8'h00);
    chk("stat cleared", in_port, 8'h00);
    pad_o = 8'h01;
    tick(2);
    wr(8'h12, 8'h01);
    tick();
    chk("edge wins", in_port, 8'h01);
    chk("edge wins irq", {7'b0, interrupt}, 8'h01);
    wr(8'h12, 8'h01);
    tick();
    chk("clr no edge", in_port, 8'h00);
    chk("clr irq", {7'b0, interrupt}, 8'h00);
`else
    pad_o = 8'hFF;
    tick(4);
    pad_o = 8'h00;
    tick(4);
    pad_o = 8'hFF;
    tick(4);
    wr(8'h13, 8'hFF);
    chk("noirq irq a", {7'b0, interrupt}, 8'h00);
    tick();
    chk("noirq mask", in_port, 8'h00);
    port_id       = 8'h12;
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    tick();
    chk("noirq stat", in_port, 8'h00);
    chk("noirq irq b", {7'b0, interrupt}, 8'h00);
`endif

    // Reset must win over a coincident DIR write.
    pad_o        = 8'h01;
    port_id      = 8'h11;
    out_port     = 8'h00;
    write_strobe = 1'b1;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    write_strobe = 1'b0;
    chk("rstwr pad_t", pad_t, 8'hFF);
    chk("rstwr pad_i", pad_i, 8'h00);
    chk("rstwr in_port", in_port, 8'h00);
    chk("rstwr irq", {7'b0, interrupt}, 8'h00);
    port_id = 8'h10;
    tick(2);
    chk("rel data c2", in_port, 8'h00);
    tick();
    chk("rel data c3", in_port, 8'h01);
    port_id = 8'h12;
    tick();
    chk("rel stat", in_port, IRQ ? 8'h01 : 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
